// File: rtl/sdm_pkg.sv
// Shared Q-format helpers and FSM encoding for the SDM link (decoder and modulator).
package sdm_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } dec_state_e;

  function automatic int unsigned frac_bits(input int unsigned bit_width,
                                            input int unsigned int_width);
    return bit_width - int_width - 32'd1;
  endfunction

  function automatic int q_one(input int unsigned bit_width, input int unsigned int_width);
    return 1 << frac_bits(bit_width, int_width);
  endfunction

  function automatic int q_neg_one(input int unsigned bit_width, input int unsigned int_width);
    return -q_one(bit_width, int_width);
  endfunction

  // Map a ones count over 2^log_win bits to the bipolar mean in Q(frac).
  function automatic int s_to_q(input int ones_t, input int unsigned log_win,
                                input int unsigned frac);
    int s;
    s = 2 * ones_t - (1 << log_win);
    return s <<< (frac - log_win);
  endfunction

endpackage

// File: rtl/bit_window_acc.sv
// Window bit counter: accepted-bit and ones counters, plus a history shift
// register when SDM_DEC_SLIDING_EN is defined.
module bit_window_acc #(
  parameter int unsigned LOG_WIN = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             y_i,
  input  logic             valid_i,
  input  logic             clr_i,
  output logic [LOG_WIN:0] ones_t_o_c,
  output logic             wrap_o_c
);

  localparam int unsigned N = 1 << LOG_WIN;

  logic [LOG_WIN-1:0] cnt_q, cnt_d;
  logic [LOG_WIN:0]   ones_q, ones_d;
  logic               accept;

  assign accept   = valid_i & ~clr_i;
  assign wrap_o_c = accept & (cnt_q == LOG_WIN'(N - 1));

`ifdef SDM_DEC_SLIDING_EN
  logic [N-1:0] sr_q, sr_d;

  // Running count: new bit in, oldest bit of the window out.
  assign ones_t_o_c = ones_q + (LOG_WIN+1)'(y_i) - (LOG_WIN+1)'(sr_q[N-1]);

  always_comb begin
    cnt_d  = cnt_q;
    ones_d = ones_q;
    sr_d   = sr_q;
    if (clr_i) begin
      cnt_d  = '0;
      ones_d = '0;
      sr_d   = '0;
    end else if (accept) begin
      cnt_d  = cnt_q + LOG_WIN'(1);
      ones_d = ones_t_o_c;
      sr_d   = {sr_q[N-2:0], y_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sr_q <= '0;
    else         sr_q <= sr_d;
  end
`else
  assign ones_t_o_c = ones_q + (LOG_WIN+1)'(y_i);

  always_comb begin
    cnt_d  = cnt_q;
    ones_d = ones_q;
    if (clr_i) begin
      cnt_d  = '0;
      ones_d = '0;
    end else if (accept) begin
      cnt_d  = cnt_q + LOG_WIN'(1);
      ones_d = wrap_o_c ? '0 : ones_t_o_c;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      ones_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/sdm_decoder.sv
// SDM bitstream to signed Q-format window mean. Block mode by default;
// SDM_DEC_SLIDING_EN enables a per-bit sliding-window output once running.
module sdm_decoder
  import sdm_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned INT_WIDTH = 1,
  parameter int unsigned LOG_WIN   = 4
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        y,
  input  logic                        in_valid,
  input  logic                        clr,
  output logic signed [BIT_WIDTH-1:0] x,
  output logic                        out_valid
);

  localparam int unsigned FRAC = frac_bits(BIT_WIDTH, INT_WIDTH);

  if (INT_WIDTH < 1 || INT_WIDTH >= BIT_WIDTH || BIT_WIDTH > 32 ||
      LOG_WIN < 1 || LOG_WIN > FRAC) begin : g_bad_cfg
    $error("sdm_decoder: illegal BIT_WIDTH/INT_WIDTH/LOG_WIN combination");
  end

  dec_state_e                  state_q, state_d;
  logic signed [BIT_WIDTH-1:0] x_q, x_d;
  logic                        ov_q, ov_d;
  logic                        emit;
  logic [LOG_WIN:0]            ones_t_c;
  logic                        wrap_c;

  bit_window_acc #(
    .LOG_WIN (LOG_WIN)
  ) u_acc (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .y_i        (y),
    .valid_i    (in_valid),
    .clr_i      (clr),
    .ones_t_o_c (ones_t_c),
    .wrap_o_c   (wrap_c)
  );

  // clr dominates; x only moves on an emitted window.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    ov_d    = 1'b0;
    emit    = 1'b0;
    if (clr) begin
      state_d = FILL;
    end else if (in_valid) begin
`ifdef SDM_DEC_SLIDING_EN
      emit = wrap_c | (state_q == RUN);
`else
      emit = wrap_c;
`endif
      if (wrap_c) state_d = RUN;
    end
    if (emit) begin
      x_d  = BIT_WIDTH'(s_to_q(int'(ones_t_c), LOG_WIN, FRAC));
      ov_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FILL;
      x_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ov_q    <= ov_d;
    end
  end

  assign x         = x_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_sdm_decoder.sv
// Self-checking bench for sdm_decoder (BIT_WIDTH=16, INT_WIDTH=1, LOG_WIN=4);
// honours SDM_DEC_SLIDING_EN in its reference model.
module tb_sdm_decoder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        y;
  logic        in_valid;
  logic        clr;
  logic [15:0] x;
  logic        out_valid;

  int          tests = 0;
  int          fails = 0;
  bit          hist[$];
  int          n_acc = 0;
  logic [15:0] exp_x = '0;
  logic        exp_ov = 1'b0;
  int          pulses = 0;
  logic [15:0] last_x = '0;

  sdm_decoder #(
    .BIT_WIDTH (16),
    .INT_WIDTH (1),
    .LOG_WIN   (4)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .y         (y),
    .in_valid  (in_valid),
    .clr       (clr),
    .x         (x),
    .out_valid (out_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mean of a 16-bit bipolar window as a real number, then scaled to Q1.14.
  function automatic logic [15:0] mean_to_q(input int ones);
    real m;
    m = 2.0 * real'(ones) / 16.0 - 1.0;
    return 16'($rtoi(m * 16384.0));
  endfunction

  function automatic int hist_sum();
    int s = 0;
    foreach (hist[i]) s += int'(hist[i]);
    return s;
  endfunction

  function automatic void model_reset();
    hist.delete();
    n_acc  = 0;
    exp_x  = '0;
    exp_ov = 1'b0;
  endfunction

  function automatic void model_step(input bit yb, input bit vb, input bit cb);
    exp_ov = 1'b0;
    if (cb) begin
      hist.delete();
      n_acc = 0;
    end else if (vb) begin
      hist.push_back(yb);
      n_acc++;
`ifdef SDM_DEC_SLIDING_EN
      if (hist.size() > 16) void'(hist.pop_front());
      if (n_acc >= 16) begin
        exp_x  = mean_to_q(hist_sum());
        exp_ov = 1'b1;
      end
`else
      if (hist.size() == 16) begin
        exp_x  = mean_to_q(hist_sum());
        exp_ov = 1'b1;
        hist.delete();
      end
`endif
    end
  endfunction

  // Drive one cycle of inputs, then check the registered outputs after the edge.
  task automatic cyc(input bit yb, input bit vb, input bit cb);
    y        = yb;
    in_valid = vb;
    clr      = cb;
    @(posedge CLK);
    #1;
    model_step(yb, vb, cb);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("x", 32'(x), 32'(exp_x));
    if (out_valid === 1'b1) begin
      pulses++;
      last_x = x;
    end
  endtask

  initial begin
    int acc;
    bit yb;
    nRST     = 1'b1;
    y        = 1'b0;
    in_valid = 1'b0;
    clr      = 1'b0;
    #2 nRST = 1'b0;
    #1;
    check("rst_x", 32'(x), 32'h0);
    check("rst_ov", 32'(out_valid), 32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1 nRST = 1'b1;
    model_reset();

    // 16 ones -> +1.0
    pulses = 0;
    repeat (16) cyc(1'b1, 1'b1, 1'b0);
    check("ones_pulses", 32'(pulses), 32'd1);
    check("ones_x", 32'(last_x), 32'h4000);

    // 16 zeros -> -1.0
    cyc(1'b0, 1'b0, 1'b1);
    pulses = 0;
    repeat (16) cyc(1'b0, 1'b1, 1'b0);
    check("zeros_pulses", 32'(pulses), 32'd1);
    check("zeros_x", 32'(last_x), 32'hC000);

    // Alternating with a 3-cycle gap between bits 5 and 6
    cyc(1'b0, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(bit'(i % 2 == 0), 1'b1, 1'b0);
      if (i == 4) repeat (3) cyc(1'b1, 1'b0, 1'b0);
    end
    check("alt_pulses", 32'(pulses), 32'd1);
    check("alt_x", 32'(last_x), 32'h0000);

    // +0.5 then -0.5
    cyc(1'b0, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 16; i++) cyc(bit'(i < 12), 1'b1, 1'b0);
    check("half_x", 32'(last_x), 32'h2000);
`ifdef SDM_DEC_SLIDING_EN
    cyc(1'b0, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 16; i++) cyc(bit'(i < 4), 1'b1, 1'b0);
    check("neghalf_x", 32'(last_x), 32'hE000);
    check("half_pulses", 32'(pulses), 32'd2);

    // Asynchronous reset mid-window
    cyc(1'b0, 1'b0, 1'b1);
    repeat (7) cyc(1'b1, 1'b1, 1'b0);
    #2 nRST = 1'b0;
    #1;
    check("async_rst_x", 32'(x), 32'h0);
    check("async_rst_ov", 32'(out_valid), 32'h0);
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("rst_hold_x", 32'(x), 32'h0);
    nRST = 1'b1;
    pulses = 0;
    repeat (15) cyc(1'b1, 1'b1, 1'b0);
    check("post_rst_early", 32'(pulses), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    check("post_rst_pulses", 32'(pulses), 32'd1);
    check("post_rst_x", 32'(last_x), 32'h4000);

    // clr on the would-be 16th bit
    cyc(1'b0, 1'b0, 1'b1);
    repeat (16) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    pulses = 0;
    repeat (15) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    check("clr16_pulses", 32'(pulses), 32'd0);
    check("clr16_hold", 32'(x), 32'hC000);
    repeat (16) cyc(1'b1, 1'b1, 1'b0);
    check("clr16_next_pulses", 32'(pulses), 32'd1);
    check("clr16_next_x", 32'(last_x), 32'h4000);

    // Loopback from a first-order modulator at +0.25
    acc = 0;
    for (int i = 0; i < 32; i++) begin
      yb  = (acc >= 0);
      acc = acc + 4096 - (yb ? 16384 : -16384);
      cyc(yb, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      yb  = (acc >= 0);
      acc = acc + 4096 - (yb ? 16384 : -16384);
      cyc(yb, 1'b1, 1'b0);
      if (out_valid === 1'b1)
        check("loop_range", 32'(int'(x) >= 32'h0800 && int'(x) <= 32'h1800), 32'd1);
    end
`ifdef SDM_DEC_SLIDING_EN
    check("loop_pulses", 32'(pulses), 32'd49);
`else
    check("loop_pulses", 32'(pulses), 32'd4);
`endif

    // Random traffic with gaps and occasional clr
    for (int i = 0; i < 600; i++)
      cyc(bit'($urandom % 2), bit'(($urandom % 4) != 0), bit'(($urandom % 40) == 0));

    in_valid = 1'b0;
    clr      = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
